// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues loads/stores on a req/ack port, stalls upstream while busy,
// passes non-memory results through, and pulses MemFault on misaligned/conflicting/timed-out ops.
module mem_access_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] AddrIn,
    input  logic [31:0] StoreValIn,
    input  logic [4:0]  DstIn,
    input  logic        WriteBackIn,
    input  logic        isMemReadIn,
    input  logic        isMemWriteIn,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemAck,
    output logic        Stall,
    output logic [4:0]  DstOut,
    output logic [31:0] WBData,
    output logic        WriteBackOut,
    output logic        MemFault
);

    // state  | meaning
    // S_IDLE | accepting a new instruction every edge
    // S_BUSY | access outstanding, MemReq held, upstream stalled

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;
    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    logic [0:0]  r_state;
    logic [7:0]  r_cnt;
    logic [4:0]  r_dst;
    logic        r_wb;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_stall;
    logic [4:0]  r_dst_out;
    logic [31:0] r_wb_data;
    logic        r_wb_out;
    logic        r_mem_fault;

    logic w_is_mem;
    logic w_bad;
    logic w_timeout;

    assign w_is_mem  = isMemReadIn | isMemWriteIn;
    assign w_bad     = (isMemReadIn & isMemWriteIn) | (w_is_mem & (AddrIn[1:0] != 2'b00));
    assign w_timeout = (r_cnt == TIMEOUT_M1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_dst       <= 5'd0;
            r_wb        <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_stall     <= 1'b0;
            r_dst_out   <= 5'd0;
            r_wb_data   <= 32'd0;
            r_wb_out    <= 1'b0;
            r_mem_fault <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_mem_fault <= 1'b0;
            if (!w_is_mem) begin
                r_wb_data <= AddrIn;
                r_dst_out <= DstIn;
                r_wb_out  <= WriteBackIn;
            end else if (w_bad) begin
                r_mem_fault <= 1'b1;
                r_wb_out    <= 1'b0;
                r_dst_out   <= DstIn;
            end else begin
                r_mem_addr  <= {AddrIn[31:2], 2'b00};
                r_mem_we    <= isMemWriteIn;
                r_mem_wdata <= StoreValIn;
                r_dst       <= DstIn;
                r_wb        <= WriteBackIn;
                r_mem_req   <= 1'b1;
                r_cnt       <= 8'd0;
                r_wb_out    <= 1'b0;
                r_state     <= S_BUSY;
                r_stall     <= 1'b1;
            end
        end else begin
            r_wb_out    <= 1'b0;
            r_mem_fault <= 1'b0;
            // ack takes priority over a timeout landing on the same edge
            if (MemAck) begin
                r_state   <= S_IDLE;
                r_stall   <= 1'b0;
                r_mem_req <= 1'b0;
                if (!r_mem_we) begin
                    r_wb_data <= MemRData;
                    r_dst_out <= r_dst;
                    r_wb_out  <= r_wb;
                end
            end else if (w_timeout) begin
                r_state     <= S_IDLE;
                r_stall     <= 1'b0;
                r_mem_req   <= 1'b0;
                r_mem_fault <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign MemReq       = r_mem_req;
    assign MemWe        = r_mem_we;
    assign MemAddr      = r_mem_addr;
    assign MemWData     = r_mem_wdata;
    assign Stall        = r_stall;
    assign DstOut       = r_dst_out;
    assign WBData       = r_wb_data;
    assign WriteBackOut = r_wb_out;
    assign MemFault     = r_mem_fault;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with TIMEOUT=4; expected values are hand-computed constants.
module tb_mem_access_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] AddrIn;
    logic [31:0] StoreValIn;
    logic [4:0]  DstIn;
    logic        WriteBackIn;
    logic        isMemReadIn;
    logic        isMemWriteIn;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData;
    logic        MemAck;
    logic        Stall;
    logic [4:0]  DstOut;
    logic [31:0] WBData;
    logic        WriteBackOut;
    logic        MemFault;

    int vectors = 0;
    int miscompares = 0;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .Clk(Clk), .Reset(Reset), .AddrIn(AddrIn), .StoreValIn(StoreValIn),
        .DstIn(DstIn), .WriteBackIn(WriteBackIn), .isMemReadIn(isMemReadIn),
        .isMemWriteIn(isMemWriteIn), .MemReq(MemReq), .MemWe(MemWe),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData),
        .MemAck(MemAck), .Stall(Stall), .DstOut(DstOut), .WBData(WBData),
        .WriteBackOut(WriteBackOut), .MemFault(MemFault)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] sv, input logic [4:0] dst, input logic wb);
        isMemReadIn  = rd;
        isMemWriteIn = wr;
        AddrIn       = addr;
        StoreValIn   = sv;
        DstIn        = dst;
        WriteBackIn  = wb;
    endtask

    initial begin
        Reset = 1'b1;
        MemAck = 1'b0;
        MemRData = 32'd0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();
        chk("rst_memreq", 32'(MemReq), 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_wbdata", WBData, 32'd0);
        chk("rst_wbout", 32'(WriteBackOut), 32'd0);
        chk("rst_fault", 32'(MemFault), 32'd0);
        chk("rst_memaddr", MemAddr, 32'd0);
        tick();
        Reset = 1'b0;

        // pass-through
        drive(1'b0, 1'b0, 32'h0000_1234, 32'd0, 5'd7, 1'b1);
        tick();
        chk("pt_wbdata", WBData, 32'h0000_1234);
        chk("pt_dst", 32'(DstOut), 32'd7);
        chk("pt_wbout", 32'(WriteBackOut), 32'd1);
        chk("pt_memreq", 32'(MemReq), 32'd0);
        chk("pt_stall", 32'(Stall), 32'd0);

        // load, ack on 3rd BUSY cycle; a different op sits on the inputs meanwhile
        drive(1'b1, 1'b0, 32'h0000_0100, 32'd0, 5'd4, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0000_0055, 32'd0, 5'd9, 1'b0);
        chk("ld_b1_req", 32'(MemReq), 32'd1);
        chk("ld_b1_we", 32'(MemWe), 32'd0);
        chk("ld_b1_addr", MemAddr, 32'h0000_0100);
        chk("ld_b1_stall", 32'(Stall), 32'd1);
        chk("ld_b1_wbout", 32'(WriteBackOut), 32'd0);
        tick();
        chk("ld_b2_req", 32'(MemReq), 32'd1);
        chk("ld_b2_stall", 32'(Stall), 32'd1);
        tick();
        chk("ld_b3_req", 32'(MemReq), 32'd1);
        chk("ld_b3_addr", MemAddr, 32'h0000_0100);
        MemAck = 1'b1;
        MemRData = 32'hDEAD_BEEF;
        tick();
        MemAck = 1'b0;
        chk("ld_done_req", 32'(MemReq), 32'd0);
        chk("ld_done_stall", 32'(Stall), 32'd0);
        chk("ld_done_data", WBData, 32'hDEAD_BEEF);
        chk("ld_done_dst", 32'(DstOut), 32'd4);
        chk("ld_done_wbout", 32'(WriteBackOut), 32'd1);
        tick();
        chk("ld_next_data", WBData, 32'h0000_0055);
        chk("ld_next_dst", 32'(DstOut), 32'd9);
        chk("ld_next_wbout", 32'(WriteBackOut), 32'd0);

        // zero-wait store followed back-to-back by a load
        drive(1'b0, 1'b1, 32'h0000_0204, 32'hA5A5_A5A5, 5'd3, 1'b1);
        tick();
        chk("st_req", 32'(MemReq), 32'd1);
        chk("st_we", 32'(MemWe), 32'd1);
        chk("st_addr", MemAddr, 32'h0000_0204);
        chk("st_wdata", MemWData, 32'hA5A5_A5A5);
        chk("st_stall", 32'(Stall), 32'd1);
        chk("st_wbout", 32'(WriteBackOut), 32'd0);
        drive(1'b1, 1'b0, 32'h0000_0300, 32'd0, 5'd5, 1'b1);
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        chk("st_done_req", 32'(MemReq), 32'd0);
        chk("st_done_stall", 32'(Stall), 32'd0);
        chk("st_done_wbout", 32'(WriteBackOut), 32'd0);
        tick();
        chk("b2b_req", 32'(MemReq), 32'd1);
        chk("b2b_we", 32'(MemWe), 32'd0);
        chk("b2b_addr", MemAddr, 32'h0000_0300);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        MemAck = 1'b1;
        MemRData = 32'h1234_5678;
        tick();
        MemAck = 1'b0;
        chk("b2b_data", WBData, 32'h1234_5678);
        chk("b2b_dst", 32'(DstOut), 32'd5);
        chk("b2b_wbout", 32'(WriteBackOut), 32'd1);

        // misaligned load
        drive(1'b1, 1'b0, 32'h0000_0102, 32'd0, 5'd6, 1'b1);
        tick();
        chk("mis_req", 32'(MemReq), 32'd0);
        chk("mis_fault", 32'(MemFault), 32'd1);
        chk("mis_wbout", 32'(WriteBackOut), 32'd0);
        chk("mis_dst", 32'(DstOut), 32'd6);
        chk("mis_stall", 32'(Stall), 32'd0);
        drive(1'b0, 1'b0, 32'h0000_0077, 32'd0, 5'd1, 1'b1);
        tick();
        chk("mis_after_fault", 32'(MemFault), 32'd0);
        chk("mis_after_data", WBData, 32'h0000_0077);
        chk("mis_after_wbout", 32'(WriteBackOut), 32'd1);

        // read and write both set
        drive(1'b1, 1'b1, 32'h0000_0400, 32'd0, 5'd2, 1'b1);
        tick();
        chk("rw_req", 32'(MemReq), 32'd0);
        chk("rw_fault", 32'(MemFault), 32'd1);
        chk("rw_wbout", 32'(WriteBackOut), 32'd0);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();
        chk("rw_after_fault", 32'(MemFault), 32'd0);

        // timeout: never acked, MemReq high 4 cycles
        drive(1'b1, 1'b0, 32'h0000_0500, 32'd0, 5'd8, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0000_0099, 32'd0, 5'd10, 1'b1);
        chk("to_b1_req", 32'(MemReq), 32'd1);
        tick();
        chk("to_b2_req", 32'(MemReq), 32'd1);
        tick();
        chk("to_b3_req", 32'(MemReq), 32'd1);
        tick();
        chk("to_b4_req", 32'(MemReq), 32'd1);
        chk("to_b4_stall", 32'(Stall), 32'd1);
        chk("to_b4_fault", 32'(MemFault), 32'd0);
        tick();
        chk("to_req", 32'(MemReq), 32'd0);
        chk("to_fault", 32'(MemFault), 32'd1);
        chk("to_stall", 32'(Stall), 32'd0);
        chk("to_wbout", 32'(WriteBackOut), 32'd0);
        tick();
        chk("to_next_fault", 32'(MemFault), 32'd0);
        chk("to_next_data", WBData, 32'h0000_0099);
        chk("to_next_dst", 32'(DstOut), 32'd10);
        chk("to_next_wbout", 32'(WriteBackOut), 32'd1);

        // ack on the same edge the timeout would fire
        drive(1'b1, 1'b0, 32'h0000_0600, 32'd0, 5'd11, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();
        tick();
        tick();
        chk("race_b4_req", 32'(MemReq), 32'd1);
        MemAck = 1'b1;
        MemRData = 32'hCAFE_F00D;
        tick();
        MemAck = 1'b0;
        chk("race_fault", 32'(MemFault), 32'd0);
        chk("race_data", WBData, 32'hCAFE_F00D);
        chk("race_dst", 32'(DstOut), 32'd11);
        chk("race_wbout", 32'(WriteBackOut), 32'd1);

        // ack while idle is ignored
        drive(1'b0, 1'b0, 32'h0000_0042, 32'd0, 5'd13, 1'b0);
        MemAck = 1'b1;
        MemRData = 32'h0BAD_0BAD;
        tick();
        MemAck = 1'b0;
        chk("idle_ack_req", 32'(MemReq), 32'd0);
        chk("idle_ack_stall", 32'(Stall), 32'd0);
        chk("idle_ack_data", WBData, 32'h0000_0042);

        // reset during 2nd BUSY cycle, then a late ack
        drive(1'b1, 1'b0, 32'h0000_0700, 32'd0, 5'd12, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();
        chk("mid_b2_req", 32'(MemReq), 32'd1);
        Reset = 1'b1;
        #1;
        chk("mid_rst_req", 32'(MemReq), 32'd0);
        chk("mid_rst_stall", 32'(Stall), 32'd0);
        tick();
        Reset = 1'b0;
        MemAck = 1'b1;
        MemRData = 32'h0000_0BAD;
        tick();
        MemAck = 1'b0;
        chk("late_ack_wbout", 32'(WriteBackOut), 32'd0);
        chk("late_ack_data", WBData, 32'd0);
        chk("late_ack_req", 32'(MemReq), 32'd0);
        chk("late_ack_stall", 32'(Stall), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
